// File: rtl/mitch_trunc_pipe_pkg.sv
// ---------------------------------------------------------------------------
// mitch_trunc_pipe_pkg
//
// Shared definitions for the truncated-Mitchell multiplier pipeline.
//
// Packages cannot take parameters, so the stage payload structs are sized
// for the largest supported operand width (NMAX = 32). Each instance uses
// only the low bits of those fields. The per-instance quantities (FRAC, KW,
// saturation value) are available as constant functions of the module
// parameters.
// ---------------------------------------------------------------------------
package mitch_trunc_pipe_pkg;

  localparam int NMAX  = 32;
  localparam int FMAX  = NMAX - 1;
  localparam int KPW   = $clog2(NMAX);
  localparam int KWMAX = $clog2(2 * NMAX) + 1;

  // Leading-one position, fraction field and exponent-sum field, all at
  // maximum width.
  typedef logic [KPW-1:0]   kpos_t;
  typedef logic [FMAX-1:0]  frac_t;
  typedef logic [KWMAX-1:0] ksum_t;

  // Payload after S1: both log terms plus the combined sign and zero flags.
  typedef struct packed {
    logic  valid;
    logic  sign;
    logic  zero;
    kpos_t kx;
    kpos_t ky;
    frac_t fx;
    frac_t fy;
  } s1_t;

  // Payload after S2: the summed log value, split into integer and fraction.
  typedef struct packed {
    logic  valid;
    logic  sign;
    logic  zero;
    ksum_t k;
    frac_t f;
  } s2_t;

  // Number of fraction bits kept below the leading one.
  function automatic int frac_of(input int w);
    return w - 1;
  endfunction

  // Width of the exponent sum kx + ky + carry.
  function automatic int kw_of(input int n);
    return $clog2(2 * n) + 1;
  endfunction

  // All-ones value of a 2n-bit product. The result is returned at maximum
  // width.
  function automatic logic [2*NMAX-1:0] sat_of(input int n);
    logic [2*NMAX-1:0] r;
    r = '0;
    for (int i = 0; i < 2 * NMAX; i++) begin
      if (i < 2 * n) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mitch_trunc_pipe_log_enc.sv
// ---------------------------------------------------------------------------
// mitch_log_enc
//
// Per-operand log encoder for the Mitchell multiplier.
//
// The block computes the magnitude of the operand. In signed mode it uses a
// one's complement with no +1 correction. It then finds the leading one and
// normalises the magnitude so that the FRAC bits directly below the leading
// one become the log fraction. Missing low bits are zero-filled, and extra
// low bits are truncated.
//
// Ports:
//   op_i     [N-1:0]  operand
//   signed_i          1 = two's complement operand, 0 = unsigned
//   sign_o            operand sign (msb in signed mode, else 0)
//   zero_o            operand is exactly zero
//   k_o               leading-one position of the magnitude (0 when magnitude is 0)
//   f_o               FRAC-bit log fraction, zero-extended to package width
// ---------------------------------------------------------------------------
module mitch_log_enc
  import mitch_trunc_pipe_pkg::*;
#(
  parameter int N    = 16,
  parameter int FRAC = 5
) (
  input  logic [N-1:0] op_i,
  input  logic         signed_i,
  output logic         sign_o,
  output logic         zero_o,
  output kpos_t        k_o,
  output frac_t        f_o
);

  logic [N-1:0]    mag;
  logic [N-1:0]    norm;
  logic [FRAC-1:0] f;

  always_comb begin
    sign_o = signed_i & op_i[N-1];
    mag    = sign_o ? ~op_i : op_i;
    zero_o = (op_i == '0);

    // The highest set bit wins. A zero magnitude (operand -1) leaves k = 0,
    // and then norm is also 0, so f = 0.
    k_o = '0;
    for (int i = 0; i < N; i++) begin
      if (mag[i]) k_o = kpos_t'(i);
    end

    // Shift the leading one to the msb, drop it, and keep the next FRAC bits.
    norm = mag << (kpos_t'(N - 1) - k_o);
    f    = FRAC'((norm << 1) >> (N - FRAC));
    f_o  = frac_t'(f);
  end

endmodule

// File: rtl/mitch_trunc_pipe.sv
// ---------------------------------------------------------------------------
// mitch_trunc_pipe
//
// Three-stage approximate multiplier based on Mitchell's logarithm method,
// with a truncated mantissa and a constant compensation bias.
//
//   S1: magnitude, leading-one detection and normalisation (two encoders)
//   S2: log addition  S = fx + fy + C, K = kx + ky + carry
//   S3: antilog shift, saturation, sign and zero handling
//
// The whole pipe advances together when in_ready is high, so a stalled
// output also freezes every upstream stage.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake
//   in_signed           1 = x, y are two's complement
//   x, y      [N-1:0]   operands
//   out_valid/out_ready product handshake
//   p       [2N-1:0]    approximate product
// ---------------------------------------------------------------------------
module mitch_trunc_pipe
  import mitch_trunc_pipe_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 6,
  parameter int C = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_signed,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p
);

  localparam int FRAC = frac_of(W);
  localparam int KW   = kw_of(N);
  // The antilog mantissa is W bits and is shifted by up to 2N positions.
  localparam int AW   = W + 2 * N;
  localparam logic [2*N-1:0]  SAT   = (2*N)'(sat_of(N));
  localparam logic [FMAX+1:0] FMASK = (FMAX+2)'((64'd1 << FRAC) - 64'd1);

  logic  sx, sy, zx, zy;
  kpos_t kx, ky;
  frac_t fx, fy;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic [2*N-1:0] p_d, p_q;
  logic           out_valid_q;

  logic [FMAX+1:0] s_sum;
  logic [KW-1:0]   k_sum;
  logic [AW-1:0]   mant, shifted, mag_full;
  logic            ovf;
  logic [2*N-1:0]  mag;

  assign in_ready  = ~out_valid_q | out_ready;
  assign out_valid = out_valid_q;
  assign p         = p_q;

  mitch_log_enc #(.N(N), .FRAC(FRAC)) u_enc_x (
    .op_i    (x),
    .signed_i(in_signed),
    .sign_o  (sx),
    .zero_o  (zx),
    .k_o     (kx),
    .f_o     (fx)
  );

  mitch_log_enc #(.N(N), .FRAC(FRAC)) u_enc_y (
    .op_i    (y),
    .signed_i(in_signed),
    .sign_o  (sy),
    .zero_o  (zy),
    .k_o     (ky),
    .f_o     (fy)
  );

  // S1 payload. The product sign and zero flag are folded here so that
  // in_signed does not need to travel further down the pipe.
  always_comb begin
    s1_d       = '0;
    s1_d.valid = in_valid;
    s1_d.sign  = sx ^ sy;
    s1_d.zero  = zx | zy;
    s1_d.kx    = kx;
    s1_d.ky    = ky;
    s1_d.fx    = fx;
    s1_d.fy    = fy;
  end

  // S2: log addition. The fraction sum can carry up to 2 into the exponent.
  always_comb begin
    s_sum = (FMAX+2)'(s1_q.fx) + (FMAX+2)'(s1_q.fy) + (FMAX+2)'(C);
    k_sum = KW'(s1_q.kx) + KW'(s1_q.ky) + KW'(s_sum >> FRAC);

    s2_d       = '0;
    s2_d.valid = s1_q.valid;
    s2_d.sign  = s1_q.sign;
    s2_d.zero  = s1_q.zero;
    s2_d.k     = ksum_t'(k_sum);
    s2_d.f     = frac_t'(s_sum & FMASK);
  end

  // S3: antilog. (1.F) is shifted left by K, then the FRAC fraction bits are
  // dropped. Any bit above 2N means the product has overflowed.
  always_comb begin
    mant     = AW'(s2_q.f) | (AW'(1) << FRAC);
    shifted  = mant << s2_q.k;
    mag_full = shifted >> FRAC;
    ovf      = |mag_full[AW-1:2*N];
    mag      = ovf ? SAT : mag_full[2*N-1:0];
    p_d      = s2_q.zero ? '0 : (mag ^ {(2*N){s2_q.sign}});
  end

  // Pipeline registers. Reset overrides any transfer in the same cycle.
  // When the output stalls, in_ready is low and every stage holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else if (in_ready) begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      p_q         <= p_d;
      out_valid_q <= s2_q.valid;
    end
  end

endmodule

// File: tb/tb_mitch_trunc_pipe.sv
// ---------------------------------------------------------------------------
// tb_mitch_trunc_pipe
//
// Self-checking bench for mitch_trunc_pipe. The main instance uses
// (16,6,2). Two extra instances, (8,4,0) and (32,8,3), are exercised by the
// random test. A negedge monitor pushes a model result for every accepted
// operand pair and records every delivered product. Each test then compares
// the two streams in order.
// ---------------------------------------------------------------------------
module tb_mitch_trunc_pipe;

  logic clk = 1'b0;
  logic rst;

  logic        in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [15:0] x, y;
  logic [31:0] p;

  logic        b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready;
  logic [7:0]  b_x, b_y;
  logic [15:0] b_p;

  logic        c_in_valid, c_in_ready, c_in_signed, c_out_valid, c_out_ready;
  logic [31:0] c_x, c_y;
  logic [63:0] c_p;

  int passed = 0;
  int total  = 0;

  logic [63:0] exp_a[$], got_a[$];
  logic [63:0] exp_b[$], got_b[$];
  logic [63:0] exp_c[$], got_c[$];

  always #5 clk = ~clk;

  mitch_trunc_pipe #(.N(16), .W(6), .C(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .x(x), .y(y), .out_valid(out_valid),
    .out_ready(out_ready), .p(p)
  );

  mitch_trunc_pipe #(.N(8), .W(4), .C(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_signed(b_in_signed), .x(b_x), .y(b_y), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .p(b_p)
  );

  mitch_trunc_pipe #(.N(32), .W(8), .C(3)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_signed(c_in_signed), .x(c_x), .y(c_y), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .p(c_p)
  );

  // Reference product computed with plain integer arithmetic.
  function automatic logic [63:0] ref_model(input int n, input int w, input int c,
                                            input logic sgn, input logic [31:0] xv,
                                            input logic [31:0] yv);
    int           frac, kx, ky, kk;
    logic [31:0]  msk, mx, my;
    logic         sx, sy;
    logic [63:0]  fx, fy, s, fr;
    logic [127:0] mag, lim;
    frac = w - 1;
    msk  = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    if (xv == 32'd0 || yv == 32'd0) return 64'd0;
    sx = sgn & xv[n-1];
    sy = sgn & yv[n-1];
    mx = sx ? (xv ^ msk) : xv;
    my = sy ? (yv ^ msk) : yv;
    kx = 0;
    ky = 0;
    for (int i = 0; i < n; i++) begin
      if (mx[i]) kx = i;
      if (my[i]) ky = i;
    end
    fx = (mx == 32'd0) ? 64'd0 : (((64'(mx) << frac) >> kx) - (64'd1 << frac));
    fy = (my == 32'd0) ? 64'd0 : (((64'(my) << frac) >> ky) - (64'd1 << frac));
    s  = fx + fy + 64'(c);
    kk = kx + ky + int'(s >> frac);
    fr = s & ((64'd1 << frac) - 64'd1);
    mag = ((128'(fr) + (128'd1 << frac)) << kk) >> frac;
    lim = 128'd1 << (2 * n);
    if (mag >= lim) mag = lim - 128'd1;
    if (sx ^ sy) mag = mag ^ (lim - 128'd1);
    return mag[63:0];
  endfunction

  // Random operand with a bias toward zero, all-ones and single-bit values.
  function automatic logic [31:0] pick(input int n);
    logic [31:0] r, msk;
    r   = $urandom;
    msk = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    case ($urandom_range(0, 7))
      0:       r = 32'd0;
      1:       r = 32'hFFFF_FFFF;
      2:       r = 32'd1 << (n - 1);
      3:       r = 32'd1 << $urandom_range(0, n - 1);
      default: r = r;
    endcase
    return r & msk;
  endfunction

  // Scoreboard monitor, sampled at negedge. Reset discards in-flight data.
  always @(negedge clk) begin
    if (rst) begin
      exp_a.delete();
      exp_b.delete();
      exp_c.delete();
    end else begin
      if (in_valid && in_ready)     exp_a.push_back(ref_model(16, 6, 2, in_signed, 32'(x), 32'(y)));
      if (out_valid && out_ready)   got_a.push_back(64'(p));
      if (b_in_valid && b_in_ready) exp_b.push_back(ref_model(8, 4, 0, b_in_signed, 32'(b_x), 32'(b_y)));
      if (b_out_valid && b_out_ready) got_b.push_back(64'(b_p));
      if (c_in_valid && c_in_ready) exp_c.push_back(ref_model(32, 8, 3, c_in_signed, c_x, c_y));
      if (c_out_valid && c_out_ready) got_c.push_back(c_p);
    end
  end

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || p !== 32'd0) $display("[TB] FAIL reset_state: out_valid=%b p=%h required 0/0", out_valid, p);
    else passed++;
    total++;
    if (b_out_valid !== 1'b0 || c_out_valid !== 1'b0) $display("[TB] FAIL reset_state_bc: out_valid=%b/%b required 0/0", b_out_valid, c_out_valid);
    else passed++;
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1) $display("[TB] FAIL ready_after_reset: in_ready=%b required 1", in_ready);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) $display("[TB] FAIL idle_after_reset: out_valid=%b required 0", out_valid);
    else passed++;
  endtask

  task automatic test_directed;
    logic        ds[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] dx[8] = '{16'd3, 16'hFFFD, 16'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h8000, 16'd1};
    logic [15:0] dy[8] = '{16'd5, 16'd5, 16'd123, 16'hFFFF, 16'd5, 16'd0, 16'd0, 16'd1};
    logic [31:0] de[8] = '{32'h0000_000E, 32'hFFFF_FFF5, 32'd0, 32'hFFFF_FFFF,
                           32'hFFFF_FFFA, 32'd0, 32'd0, 32'd1};
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'b1;
      in_signed = ds[i];
      x         = dx[i];
      y         = dy[i];
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      total++;
      if (lat !== 3) $display("[TB] FAIL latency_%0d: got %0d cycles required 3", i, lat);
      else passed++;
      total++;
      if (p !== de[i]) $display("[TB] FAIL directed_%0d: got %h required %h", i, p, de[i]);
      else passed++;
    end
    @(posedge clk);
    #1;
    exp_a.delete();
    got_a.delete();
  endtask

  task automatic test_back_to_back;
    int          idx = 0;
    int          cyc = 0;
    logic [31:0] held = '0;
    logic [63:0] g, e;
    out_ready = 1'b1;
    while ((idx < 8 || got_a.size() < 8) && cyc < 100) begin
      @(posedge clk);
      #1;
      out_ready = !(cyc >= 5 && cyc < 10);
      in_valid  = (idx < 8);
      in_signed = idx[0];
      x         = 16'(idx * 4099 + 77);
      y         = 16'(idx * 911 + 3);
      @(negedge clk);
      if (cyc == 5) held = p;
      if (cyc >= 5 && cyc < 10) begin
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("[TB] FAIL stall_ready_c%0d: in_ready=%b out_valid=%b required 0/1", cyc, in_ready, out_valid);
        else passed++;
        total++;
        if (p !== held) $display("[TB] FAIL stall_hold_c%0d: p=%h required %h", cyc, p, held);
        else passed++;
      end
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (got_a.size() !== 8 || exp_a.size() !== 8) $display("[TB] FAIL b2b_count: got %0d results for %0d accepted, required 8/8", got_a.size(), exp_a.size());
    else passed++;
    for (int n = 0; got_a.size() > 0 && exp_a.size() > 0; n++) begin
      g = got_a.pop_front();
      e = exp_a.pop_front();
      total++;
      if (g !== e) $display("[TB] FAIL b2b_result_%0d: got %h required %h", n, g, e);
      else passed++;
    end
    exp_a.delete();
    got_a.delete();
  endtask

  task automatic test_reset_inflight;
    int          stale = 0;
    int          lat;
    logic [63:0] g, e;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'b1;
      in_signed = 1'b1;
      x         = 16'($urandom);
      y         = 16'($urandom);
    end
    // Reset arrives while the output stage is stalled with valid data.
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("[TB] FAIL rst_flush: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    else passed++;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) stale++;
    end
    total++;
    if (stale !== 0 || got_a.size() !== 0) $display("[TB] FAIL rst_no_stale: %0d stale cycles, %0d results required 0/0", stale, got_a.size());
    else passed++;
    in_valid  = 1'b1;
    in_signed = 1'b1;
    x         = 16'd3;
    y         = 16'd5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (lat !== 3 || p !== 32'h0000_000E) $display("[TB] FAIL rst_recover: latency %0d p=%h required 3 0000000e", lat, p);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (got_a.size() !== 1 || exp_a.size() !== 1) $display("[TB] FAIL rst_count: got %0d results for %0d accepted, required 1/1", got_a.size(), exp_a.size());
    else passed++;
    while (got_a.size() > 0 && exp_a.size() > 0) begin
      g = got_a.pop_front();
      e = exp_a.pop_front();
      total++;
      if (g !== e) $display("[TB] FAIL rst_result: got %h required %h", g, e);
      else passed++;
    end
    exp_a.delete();
    got_a.delete();
  endtask

  task automatic test_random;
    logic [63:0] g, e;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk);
      #1;
      in_valid    = ($urandom_range(0, 3) != 0);
      in_signed   = 1'($urandom_range(0, 1));
      x           = 16'(pick(16));
      y           = 16'(pick(16));
      out_ready   = ($urandom_range(0, 4) != 0);
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_in_signed = 1'($urandom_range(0, 1));
      b_x         = 8'(pick(8));
      b_y         = 8'(pick(8));
      b_out_ready = ($urandom_range(0, 4) != 0);
      c_in_valid  = ($urandom_range(0, 3) != 0);
      c_in_signed = 1'($urandom_range(0, 1));
      c_x         = pick(32);
      c_y         = pick(32);
      c_out_ready = ($urandom_range(0, 4) != 0);
    end
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    b_in_valid  = 1'b0;
    c_in_valid  = 1'b0;
    out_ready   = 1'b1;
    b_out_ready = 1'b1;
    c_out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (got_a.size() !== exp_a.size() || got_b.size() !== exp_b.size() || got_c.size() !== exp_c.size())
      $display("[TB] FAIL rand_count: results %0d/%0d/%0d accepted %0d/%0d/%0d",
               got_a.size(), got_b.size(), got_c.size(), exp_a.size(), exp_b.size(), exp_c.size());
    else passed++;
    for (int n = 0; got_a.size() > 0 && exp_a.size() > 0; n++) begin
      g = got_a.pop_front();
      e = exp_a.pop_front();
      total++;
      if (g !== e) $display("[TB] FAIL rand_16_6_2_%0d: got %h required %h", n, g, e);
      else passed++;
    end
    for (int n = 0; got_b.size() > 0 && exp_b.size() > 0; n++) begin
      g = got_b.pop_front();
      e = exp_b.pop_front();
      total++;
      if (g !== e) $display("[TB] FAIL rand_8_4_0_%0d: got %h required %h", n, g, e);
      else passed++;
    end
    for (int n = 0; got_c.size() > 0 && exp_c.size() > 0; n++) begin
      g = got_c.pop_front();
      e = exp_c.pop_front();
      total++;
      if (g !== e) $display("[TB] FAIL rand_32_8_3_%0d: got %h required %h", n, g, e);
      else passed++;
    end
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_signed   = 1'b0;
    x           = '0;
    y           = '0;
    out_ready   = 1'b1;
    b_in_valid  = 1'b0;
    b_in_signed = 1'b0;
    b_x         = '0;
    b_y         = '0;
    b_out_ready = 1'b1;
    c_in_valid  = 1'b0;
    c_in_signed = 1'b0;
    c_x         = '0;
    c_y         = '0;
    c_out_ready = 1'b1;
    $display("[TB] start");
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
